// File: rtl/sr_ff_pkg.sv
// Shared definitions for the flip-flop bank: mode encodings and their type.
package sr_ff_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_t;

    localparam int MODE_W = 2;

endpackage

// File: rtl/ff_cell.sv
// One flip-flop channel with run-time selectable SR/JK/D/T behaviour.
// The forbidden SR input (S=R=1) holds state and is flagged on illegal_nxt;
// the flag is left unregistered so the bank can register all channels in one place.
module ff_cell
    import sr_ff_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic              s,
    input  logic              r,
    output logic              q,
    output logic              illegal_nxt
);

    logic  r_q;
    logic  w_q_nxt;
    mode_t w_mode;

    assign w_mode = mode_t'(mode);

    // Next-state function; every mode starts from hold so en=0 and the
    // forbidden SR input both fall out naturally.
    always_comb begin
        w_q_nxt = r_q;
        if (en) begin
            case (w_mode)
                MODE_SR: begin
                    case ({s, r})
                        2'b10:   w_q_nxt = 1'b1;
                        2'b01:   w_q_nxt = 1'b0;
                        default: w_q_nxt = r_q;
                    endcase
                end
                MODE_JK: begin
                    case ({s, r})
                        2'b10:   w_q_nxt = 1'b1;
                        2'b01:   w_q_nxt = 1'b0;
                        2'b11:   w_q_nxt = ~r_q;
                        default: w_q_nxt = r_q;
                    endcase
                end
                MODE_D:  w_q_nxt = s;
                MODE_T:  w_q_nxt = s ? ~r_q : r_q;
            endcase
        end
    end

    // State register; reset wins immediately and drops any pending update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= RST_VAL;
        else     r_q <= w_q_nxt;
    end

    assign q           = r_q;
    assign illegal_nxt = en & (w_mode == MODE_SR) & s & r;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH mode-selectable flip-flops with forbidden-SR detection.
// Owns the registered per-channel illegal flags, the sticky error bit and
// the saturating count of edges that saw at least one illegal channel.
module sr_ff_bank
    import sr_ff_pkg::*;
#(
    parameter int                WIDTH   = 4,
    parameter int                CNT_W   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  s,
    input  logic [WIDTH-1:0]  r,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qn,
    output logic [WIDTH-1:0]  illegal,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_illegal_nxt;
    logic             w_any_illegal;
    logic [WIDTH-1:0] r_illegal;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_err_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell #(
            .RST_VAL (RST_VAL[i])
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .en          (en),
            .mode        (mode),
            .s           (s[i]),
            .r           (r[i]),
            .q           (w_q[i]),
            .illegal_nxt (w_illegal_nxt[i])
        );
    end

    assign w_any_illegal = |w_illegal_nxt;

    // Per-edge illegal flags; the cells already gate with en, so en=0 clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_illegal <= '0;
        else     r_illegal <= w_illegal_nxt;
    end

    // Sticky bit and saturating counter; a new event on a clearing edge wins
    // and restarts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else if (w_any_illegal) begin
            r_err_sticky <= 1'b1;
            if (clr_err)                 r_err_cnt <= CNT_ONE;
            else if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + CNT_ONE;
        end else if (clr_err) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end
    end

    assign q          = w_q;
    assign qn         = ~w_q;
    assign illegal    = r_illegal;
    assign err_sticky = r_err_sticky;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed plus random bench for sr_ff_bank against a behavioural model.
module tb_sr_ff_bank;
    import sr_ff_pkg::*;

    localparam int               WIDTH   = 4;
    localparam int               CNT_W   = 2;
    localparam logic [WIDTH-1:0] RST_VAL = 4'b1010;
    localparam int               CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] s = '0;
    logic [WIDTH-1:0] r = '0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] q, qn, illegal;
    logic             err_sticky;
    logic [CNT_W-1:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    int m_q [WIDTH];
    int m_ill [WIDTH];
    int m_sticky;
    int m_cnt;

    sr_ff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RST_VAL(RST_VAL)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r),
        .clr_err(clr_err), .q(q), .qn(qn), .illegal(illegal),
        .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int v [WIDTH]);
        logic [31:0] x = '0;
        for (int i = 0; i < WIDTH; i++) x[i] = (v[i] != 0);
        return x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WIDTH; i++) begin
            m_q[i]   = RST_VAL[i] ? 1 : 0;
            m_ill[i] = 0;
        end
        m_sticky = 0;
        m_cnt    = 0;
    endtask

    // Behavioural update from the truth tables.
    task automatic model_edge(input int e, input int md, input int sv, input int rv, input int clr);
        int any = 0;
        for (int i = 0; i < WIDTH; i++) begin
            int si = (sv >> i) & 1;
            int ri = (rv >> i) & 1;
            m_ill[i] = 0;
            if (e != 0) begin
                if (md == 0) begin
                    if (si == 1 && ri == 0) m_q[i] = 1;
                    else if (si == 0 && ri == 1) m_q[i] = 0;
                    else if (si == 1 && ri == 1) m_ill[i] = 1;
                end else if (md == 1) begin
                    if (si == 1 && ri == 1) m_q[i] = 1 - m_q[i];
                    else if (si == 1) m_q[i] = 1;
                    else if (ri == 1) m_q[i] = 0;
                end else if (md == 2) begin
                    m_q[i] = si;
                end else begin
                    if (si == 1) m_q[i] = 1 - m_q[i];
                end
            end
            any += m_ill[i];
        end
        if (any > 0) begin
            m_sticky = 1;
            m_cnt = (clr != 0) ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
        end else if (clr != 0) begin
            m_sticky = 0;
            m_cnt    = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] mq;
        mq = pack(m_q);
        check({tag, ".q"},       32'(q),          mq);
        check({tag, ".qn"},      32'(qn),         (~mq) & 32'hF);
        check({tag, ".illegal"}, 32'(illegal),    pack(m_ill));
        check({tag, ".sticky"},  32'(err_sticky), 32'(m_sticky));
        check({tag, ".cnt"},     32'(err_cnt),    32'(m_cnt));
    endtask

    // Drive away from the active edge, clock it, then sample after the edge.
    task automatic step(input string tag, input logic e, input logic [1:0] md,
                        input logic [WIDTH-1:0] sv, input logic [WIDTH-1:0] rv, input logic clr);
        @(negedge clk);
        en = e; mode = md; s = sv; r = rv; clr_err = clr;
        @(posedge clk);
        model_edge(int'(e), int'(md), int'(sv), int'(rv), int'(clr));
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("rst0");
        @(negedge clk);
        rst = 1'b0;

        // SR directed
        step("sr_set",  1'b1, MODE_SR, 4'b0011, 4'b1100, 1'b0);
        check("sr_set_const", 32'(q), 32'h3);
        step("sr_hold", 1'b1, MODE_SR, 4'b0000, 4'b0000, 1'b0);
        step("sr_ill",  1'b1, MODE_SR, 4'b0001, 4'b0001, 1'b0);
        check("sr_ill_const", 32'(illegal), 32'h1);
        check("sr_ill_cnt",   32'(err_cnt), 32'h1);

        // JK then T
        step("jk_tog1", 1'b1, MODE_JK, 4'b1111, 4'b1111, 1'b0);
        check("jk_tog1_const", 32'(q), 32'hC);
        step("jk_tog2", 1'b1, MODE_JK, 4'b1111, 4'b1111, 1'b0);
        step("t_tog",   1'b1, MODE_T,  4'b0101, 4'b0000, 1'b0);
        check("t_tog_const", 32'(q), 32'h6);

        // D with enable gating
        step("d_en0", 1'b0, MODE_D, 4'b1001, 4'b0000, 1'b0);
        step("d_en1", 1'b1, MODE_D, 4'b1001, 4'b0000, 1'b0);
        check("d_qn_const", 32'(qn), 32'h6);

        // Saturation from a cleared counter
        step("clr", 1'b1, MODE_D, 4'b1001, 4'b0000, 1'b1);
        for (int k = 0; k < 5; k++) step("sat", 1'b1, MODE_SR, 4'b1111, 4'b1111, 1'b0);
        check("sat_const", 32'(err_cnt), 32'h3);
        step("en0_ill_clears", 1'b0, MODE_SR, 4'b1111, 4'b1111, 1'b0);

        // Clear collision then plain clear
        step("clr_coll", 1'b1, MODE_SR, 4'b0100, 4'b0100, 1'b1);
        check("clr_coll_cnt", 32'(err_cnt), 32'h1);
        step("clr_plain", 1'b1, MODE_SR, 4'b0000, 4'b0000, 1'b1);
        check("clr_plain_sticky", 32'(err_sticky), 32'h0);

        // Random traffic
        for (int k = 0; k < 60; k++) begin
            step("rand", logic'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 4'($urandom), 4'($urandom), logic'($urandom_range(0, 7) == 0));
        end

        // Async reset mid-cycle, with a pending update on the inputs
        step("pre_rst", 1'b1, MODE_SR, 4'b0011, 4'b0011, 1'b0);
        @(negedge clk);
        en = 1'b1; mode = MODE_D; s = 4'b0101; r = 4'b0000; clr_err = 1'b0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("arst_q_const",  32'(q),  32'hA);
        check("arst_qn_const", 32'(qn), 32'h5);
        check_all("arst");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b1, MODE_D, 4'b0101, 4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- Parametrised bank of WIDTH edge-triggered flip-flop channels, the clocked, multi-bit successor to the team's single gated SR NOR latch.
- Run-time mode select gives SR, JK, D or T behaviour per clock edge, with a common enable.
- Detects the forbidden SR condition (S=R=1) per channel, holds state instead of going indeterminate, and reports it through per-cycle flags, a sticky error bit and a saturating event counter.
- Used as a generic state-holding primitive in lab datapaths and testbenches.

Parameters:
- WIDTH, 4: number of independent flip-flop channels.
- CNT_W, 8: width of the illegal-event counter.
- RST_VAL, 0: WIDTH-bit value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  update enable; 0 = all channels hold.
- mode  input  2  00 SR, 01 JK, 10 D, 11 T; sampled every edge.
- s  input  WIDTH  per-channel S / J / D / T input.
- r  input  WIDTH  per-channel R / K input; ignored in D and T modes.
- clr_err  input  1  synchronous clear of err_sticky and err_cnt.
- q  output  WIDTH  flip-flop state.
- qn  output  WIDTH  always ~q, derived combinationally from q; never independently stored.
- illegal  output  WIDTH  registered; bit i = 1 for one cycle after an edge where channel i saw S=R=1 in SR mode with en=1.
- err_sticky  output  1  set on any illegal event; cleared only by rst or clr_err.
- err_cnt  output  CNT_W  count of clock edges with at least one illegal channel; saturates at 2^CNT_W-1.

Behaviour:
- Reset (async, immediate on rst=1 regardless of clk):
  - q=RST_VAL, qn=~RST_VAL.
  - illegal=0, err_sticky=0, err_cnt=0.
  - Reset mid-operation discards any pending update. The first edge after rst falls behaves normally.
- Update rule at each rising clk edge with en=1, per channel i, new q[i] = f(mode, s[i], r[i], q[i]):
  - SR: 00 hold, 10 set, 01 reset, 11 hold + illegal.
  - JK: 00 hold, 10 set, 01 reset, 11 toggle.
  - D: q=s[i].
  - T: s[i]=1 toggles, 0 holds.
- en=0: q holds and illegal is cleared to 0. err_sticky and err_cnt hold, subject to clr_err.
- Latency: inputs sampled at edge N appear on q, illegal, err_sticky and err_cnt right after edge N.
- Mode changes take effect on the same edge they are sampled. No state is carried across a mode change except q.
- illegal is the registered per-channel flag for the current edge only; it is not sticky.
- Error counting:
  - err_cnt increments by 1 per edge where any illegal bit is set, not by the number of channels.
  - At saturation err_cnt stays at max and err_sticky stays 1.
- clr_err (synchronous):
  - err_sticky=0 and err_cnt=0 on the edge, unless an illegal event occurs on that same edge. In that case err_sticky=1 and err_cnt=1 (the new event wins over the clear).
  - clr_err does not affect q or illegal.
- No combinational path from the inputs to q. qn glitches only with q.

Decomposition:
- Shared package sr_ff_pkg:
  - mode encodings MODE_SR=2'b00, MODE_JK=2'b01, MODE_D=2'b10, MODE_T=2'b11;
  - mode_t typedef.
- Sub-module ff_cell (one channel):
  - ports clk, rst, en, mode, s, r → q, illegal_nxt;
  - reset value passed as a 1-bit parameter.
- Top generates WIDTH ff_cell instances and owns the illegal register, sticky bit and saturating counter.

Test Plan:
- Reset: assert rst=1 asynchronously mid-cycle with RST_VAL=4'b1010 → q=1010 and qn=0101 immediately. illegal, err_sticky and err_cnt are 0 before the next edge.
- SR mode, en=1:
  - s=0011, r=1100 → q=0011.
  - Then s=r=0000 → q holds 0011.
  - Then s=0001, r=0001 → q holds 0011, illegal=0001, err_sticky=1, err_cnt=1.
- JK then T:
  - q=0011, mode=JK, s=r=1111 → q=1100. Repeat → q=0011.
  - mode=T, s=0101 → q=0110.
- D mode with enable gating:
  - mode=D, s=1001, en=0 → q unchanged.
  - en=1 → q=1001, qn=0110.
- Counter saturation: CNT_W=2, drive an SR illegal condition for 5 consecutive edges → err_cnt goes 1,2,3,3,3 and err_sticky stays 1.
- Clear collision:
  - clr_err=1 on the same edge as an illegal event → err_sticky=1, err_cnt=1.
  - Next edge, clr_err=1 with no event → err_sticky=0, err_cnt=0; q unaffected throughout.
